aibcr3aux_osc_div: RTL and testbench
====================================

Name: aibcr3aux_osc_div

Overview:
- Downstream consumer of the aux oscillator delay chain.
- Clocked by the chain's clkout, which is used as clk here.
- Takes the chain's ready output q as osc_rdy and re-synchronizes it.
- After a settle window, produces a glitch-free, programmable-ratio divided clock plus a rising-edge tick for aux-domain timers.

Parameters:
- CNT_W, 8, width of the half-period counter and div_ratio.
- SYNC_STAGES, 2, flop stages on osc_rdy (minimum 2).
- SETTLE_CYC, 16, cycles held in SETTLE before the divider starts (minimum 1).

Ports:
- clk  input  1  oscillator clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- osc_rdy  input  1  delay-chain ready; asynchronous to this block's sampling, so it is synchronized.
- div_en  input  1  request divider running; level.
- div_ratio  input  CNT_W  half-period minus 1; output period = 2*(div_ratio+1) clk cycles.
- clk_div  output  1  divided clock; registered, no combinational path.
- tick  output  1  one-cycle pulse, high in the cycle clk_div becomes 1.
- div_active  output  1  high in RUN and DRAIN.
- ratio_upd  output  1  one-cycle pulse when a new div_ratio value is loaded.
- abort  output  1  one-cycle pulse when osc_rdy loss kills SETTLE/RUN/DRAIN.

Behaviour:
- Reset: state IDLE; counter 0; sync chain 0; latched ratio 0; all outputs 0. A mid-operation reset forces clk_div low at the next edge, truncating any high phase.
- osc_rdy_s is the last stage of the sync chain; latency is SYNC_STAGES edges.
- IDLE:
  - clk_div=0.
  - If osc_rdy_s && div_en: go to SETTLE, cnt=SETTLE_CYC-1.
- SETTLE:
  - cnt decrements each cycle.
  - At cnt==0: go to RUN, latch div_ratio into ratio_q, cnt=div_ratio, clk_div stays 0.
  - If div_en drops: go to IDLE, no abort pulse.
- RUN:
  - cnt decrements.
  - At cnt==0: clk_div toggles and cnt reloads.
  - On a 0->1 toggle: tick=1.
  - On a 1->0 toggle (full-period boundary): sample div_ratio into ratio_q, reload cnt from the new value, pulse ratio_upd if it differs from the old ratio_q.
  - On a 0->1 toggle: reload from ratio_q (unchanged), so ratio changes never alter a half-period in progress.
- div_en low in RUN:
  - If clk_div=1: go to DRAIN.
  - If clk_div=0: go to IDLE next edge, clk_div stays 0.
- DRAIN: finish the high phase, then drive clk_div=0 and go to IDLE at the same edge.
- osc_rdy_s low in SETTLE, RUN or DRAIN: next edge goes to IDLE, clk_div=0, abort=1 for one cycle. This may truncate a high phase. It takes priority over div_en handling.
- rst takes priority over everything.
- div_ratio=0 is legal: clk_div toggles every cycle (clk/2).
- The counter never wraps; it is always reloaded at 0.
- First-edge latency: with osc_rdy first sampled at edge 1, the first clk_div rise is at edge SYNC_STAGES+1+SETTLE_CYC+div_ratio+1.
- div_en re-asserted in IDLE restarts from SETTLE; there is no memory of the previous run.

Decomposition:
- Package aibcr3aux_osc_pkg holds:
  - the state enum (IDLE, SETTLE, RUN, DRAIN);
  - default constants for CNT_W, SYNC_STAGES, SETTLE_CYC.
- One sub-module, aibcr3aux_osc_sync: SYNC_STAGES-deep synchronizer with synchronous active-high reset, instanced for osc_rdy.
- FSM, counter and output registers live in the top module.

Test Plan:
- Startup, defaults, div_ratio=3: rst high 3 cycles, then div_en=1, osc_rdy=1 sampled at edge 1 -> first clk_div rise and tick at edge 23; clk_div period 8 with 4 high / 4 low; div_active=1 from edge 19.
- Ratio change mid-high-phase: in RUN with ratio 3, set div_ratio=1 while clk_div=1 -> current high phase stays 4 cycles; ratio_upd pulses at the falling edge; subsequent period is 4 cycles.
- div_en drop: drop while clk_div=1 with 2 high cycles left -> DRAIN; clk_div falls after those 2 cycles; IDLE; div_active=0 same edge. Drop while clk_div=0 -> IDLE next edge, no extra pulse.
- osc_rdy loss: deassert in RUN -> after SYNC_STAGES edges plus 1, clk_div=0, abort pulses once, state IDLE; re-assert -> full SETTLE_CYC window repeats.
- div_ratio=0 edge case: clk_div toggles every cycle; tick high every other cycle; no ratio_upd while div_ratio stays 0.
- Synchronous reset during RUN with clk_div=1: rst asserted one cycle -> next edge all outputs 0, state IDLE; no tick on release until the full startup sequence repeats.

Source files
------------

// File: rtl/aibcr3aux_osc_pkg.sv
// Shared types and defaults for the aux oscillator clock divider.
// Holds the controller state encoding and default sizing constants.
package aibcr3aux_osc_pkg;

    localparam int DEF_CNT_W       = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_SETTLE_CYC  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } osc_state_e;

    function automatic int clamp_min(input int val, input int lo);
        return (val < lo) ? lo : val;
    endfunction

endpackage

// File: rtl/aibcr3aux_osc_sync.sv
// Multi-stage level synchronizer with synchronous active-high reset.
// Depth never drops below two flops.
module aibcr3aux_osc_sync
    import aibcr3aux_osc_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    localparam int N = clamp_min(STAGES, 2);

    logic [N-1:0] sync_q;
    logic [N-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[N-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[N-1];

endmodule

// File: rtl/aibcr3aux_osc_div.sv
// Programmable glitch-free divider on the aux oscillator clock, started
// after a settle window once the synchronized ready level is seen.
module aibcr3aux_osc_div
    import aibcr3aux_osc_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             osc_rdy,
    input  logic             div_en,
    input  logic [CNT_W-1:0] div_ratio,
    output logic             clk_div,
    output logic             tick,
    output logic             div_active,
    output logic             ratio_upd,
    output logic             abort
);

    localparam int               SETTLE_C    = clamp_min(SETTLE_CYC, 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_C - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic osc_rdy_s;

    osc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ratio_q, ratio_d;
    logic             clk_div_q, clk_div_d;
    logic             tick_q, tick_d;
    logic             ratio_upd_q, ratio_upd_d;
    logic             abort_q, abort_d;

    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_dec;

    aibcr3aux_osc_sync #(
        .STAGES (SYNC_STAGES)
    ) u_rdy_sync (
        .clk (clk),
        .rst (rst),
        .d   (osc_rdy),
        .q   (osc_rdy_s)
    );

    assign cnt_zero = (cnt_q == '0);
    assign cnt_dec  = cnt_q - CNT_ONE;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ratio_d     = ratio_q;
        clk_div_d   = clk_div_q;
        tick_d      = 1'b0;
        ratio_upd_d = 1'b0;
        abort_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                clk_div_d = 1'b0;
                cnt_d     = '0;
                if (osc_rdy_s && div_en) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end
            end

            ST_SETTLE: begin
                if (!osc_rdy_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                end else if (!div_en) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_zero) begin
                    state_d = ST_RUN;
                    ratio_d = div_ratio;
                    cnt_d   = div_ratio;
                end else begin
                    cnt_d = cnt_dec;
                end
            end

            ST_RUN: begin
                if (!osc_rdy_s) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    clk_div_d = 1'b0;
                    abort_d   = 1'b1;
                end else if (!div_en) begin
                    // A low phase can stop at once; a high phase must finish.
                    if (!clk_div_q || cnt_zero) begin
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                        clk_div_d = 1'b0;
                    end else begin
                        state_d = ST_DRAIN;
                        cnt_d   = cnt_dec;
                    end
                end else if (cnt_zero) begin
                    if (clk_div_q) begin
                        clk_div_d   = 1'b0;
                        ratio_d     = div_ratio;
                        cnt_d       = div_ratio;
                        ratio_upd_d = (div_ratio != ratio_q);
                    end else begin
                        clk_div_d = 1'b1;
                        tick_d    = 1'b1;
                        cnt_d     = ratio_q;
                    end
                end else begin
                    cnt_d = cnt_dec;
                end
            end

            ST_DRAIN: begin
                if (!osc_rdy_s) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    clk_div_d = 1'b0;
                    abort_d   = 1'b1;
                end else if (cnt_zero) begin
                    state_d   = ST_IDLE;
                    clk_div_d = 1'b0;
                end else begin
                    cnt_d = cnt_dec;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                clk_div_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ratio_q     <= '0;
            clk_div_q   <= 1'b0;
            tick_q      <= 1'b0;
            ratio_upd_q <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ratio_q     <= ratio_d;
            clk_div_q   <= clk_div_d;
            tick_q      <= tick_d;
            ratio_upd_q <= ratio_upd_d;
            abort_q     <= abort_d;
        end
    end

    assign clk_div    = clk_div_q;
    assign tick       = tick_q;
    assign ratio_upd  = ratio_upd_q;
    assign abort      = abort_q;
    assign div_active = (state_q == ST_RUN) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_aibcr3aux_osc_div.sv
// Directed bench for the aux oscillator divider with default parameters.
// Edge numbers count rising clk edges from the first one that samples osc_rdy.
module tb_aibcr3aux_osc_div;

    logic       clk;
    logic       rst;
    logic       osc_rdy;
    logic       div_en;
    logic [7:0] div_ratio;
    logic       clk_div;
    logic       tick;
    logic       div_active;
    logic       ratio_upd;
    logic       abort;

    int errors;
    int checks;
    int e;
    int tick_cnt;
    int upd_cnt;
    int abort_cnt;

    aibcr3aux_osc_div dut (
        .clk        (clk),
        .rst        (rst),
        .osc_rdy    (osc_rdy),
        .div_en     (div_en),
        .div_ratio  (div_ratio),
        .clk_div    (clk_div),
        .tick       (tick),
        .div_active (div_active),
        .ratio_upd  (ratio_upd),
        .abort      (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got %0d want %0d", tag, e, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        e++;
        if (tick)      tick_cnt++;
        if (ratio_upd) upd_cnt++;
        if (abort)     abort_cnt++;
    endtask

    task automatic run_to(input int n);
        while (e < n) step();
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        e         = 0;
        tick_cnt  = 0;
        upd_cnt   = 0;
        abort_cnt = 0;
        rst       = 1'b1;
        osc_rdy   = 1'b0;
        div_en    = 1'b0;
        div_ratio = 8'd0;

        repeat (3) step();
        chk("rst_clk_div", clk_div, 0);
        chk("rst_tick", tick, 0);
        chk("rst_active", div_active, 0);
        chk("rst_upd", ratio_upd, 0);
        chk("rst_abort", abort, 0);

        // startup with ratio 3
        rst       = 1'b0;
        div_en    = 1'b1;
        osc_rdy   = 1'b1;
        div_ratio = 8'd3;
        e         = 0;
        tick_cnt  = 0;
        run_to(18); chk("su_active18", div_active, 0);
        run_to(19); chk("su_active19", div_active, 1);
        run_to(22); chk("su_clk22", clk_div, 0);
        chk("su_noticks", tick_cnt, 0);
        run_to(23); chk("su_clk23", clk_div, 1);
        chk("su_tick23", tick, 1);
        run_to(24); chk("su_tick24", tick, 0);
        run_to(26); chk("su_clk26", clk_div, 1);
        run_to(27); chk("su_clk27", clk_div, 0);
        run_to(30); chk("su_clk30", clk_div, 0);
        run_to(31); chk("su_clk31", clk_div, 1);
        chk("su_tick31", tick, 1);

        // ratio change during high phase
        div_ratio = 8'd1;
        run_to(34); chk("rc_clk34", clk_div, 1);
        chk("rc_upd34", ratio_upd, 0);
        run_to(35); chk("rc_clk35", clk_div, 0);
        chk("rc_upd35", ratio_upd, 1);
        run_to(36); chk("rc_upd36", ratio_upd, 0);
        run_to(37); chk("rc_clk37", clk_div, 1);
        chk("rc_tick37", tick, 1);
        run_to(39); chk("rc_clk39", clk_div, 0);
        chk("rc_upd39", ratio_upd, 0);
        run_to(41); chk("rc_clk41", clk_div, 1);

        // back to 3, then drop div_en mid high phase
        div_ratio = 8'd3;
        run_to(43); chk("dr_clk43", clk_div, 0);
        chk("dr_upd43", ratio_upd, 1);
        run_to(47); chk("dr_clk47", clk_div, 1);
        run_to(48);
        div_en = 1'b0;
        run_to(49); chk("dr_clk49", clk_div, 1);
        chk("dr_active49", div_active, 1);
        run_to(50); chk("dr_clk50", clk_div, 1);
        run_to(51); chk("dr_clk51", clk_div, 0);
        chk("dr_active51", div_active, 0);

        // restart, then drop div_en during a low phase
        div_en = 1'b1;
        run_to(67); chk("dl_active67", div_active, 0);
        run_to(68); chk("dl_active68", div_active, 1);
        run_to(69); chk("dl_clk69", clk_div, 0);
        div_en = 1'b0;
        run_to(70); chk("dl_active70", div_active, 0);
        tick_cnt = 0;
        run_to(75); chk("dl_noticks", tick_cnt, 0);
        chk("dl_clk75", clk_div, 0);

        // osc_rdy loss truncates a high phase
        div_en = 1'b1;
        run_to(96); chk("ab_clk96", clk_div, 1);
        osc_rdy   = 1'b0;
        abort_cnt = 0;
        run_to(98); chk("ab_clk98", clk_div, 1);
        chk("ab_abort98", abort, 0);
        run_to(99); chk("ab_clk99", clk_div, 0);
        chk("ab_abort99", abort, 1);
        chk("ab_active99", div_active, 0);
        run_to(100); chk("ab_abort100", abort, 0);
        osc_rdy = 1'b1;
        run_to(118); chk("ab_active118", div_active, 0);
        run_to(119); chk("ab_active119", div_active, 1);
        run_to(122); chk("ab_clk122", clk_div, 0);
        run_to(123); chk("ab_clk123", clk_div, 1);
        chk("ab_tick123", tick, 1);
        chk("ab_once", abort_cnt, 1);

        // ratio 0 gives clk/2
        div_ratio = 8'd0;
        run_to(127); chk("r0_clk127", clk_div, 0);
        chk("r0_upd127", ratio_upd, 1);
        tick_cnt = 0;
        upd_cnt  = 0;
        run_to(128); chk("r0_clk128", clk_div, 1);
        chk("r0_tick128", tick, 1);
        run_to(129); chk("r0_clk129", clk_div, 0);
        chk("r0_tick129", tick, 0);
        run_to(135); chk("r0_ticks", tick_cnt, 4);
        chk("r0_noupd", upd_cnt, 0);
        run_to(136); chk("r0_clk136", clk_div, 1);

        // synchronous reset while clk_div is high
        rst = 1'b1;
        run_to(137);
        rst = 1'b0;
        chk("sr_clk", clk_div, 0);
        chk("sr_tick", tick, 0);
        chk("sr_active", div_active, 0);
        chk("sr_upd", ratio_upd, 0);
        chk("sr_abort", abort, 0);
        tick_cnt = 0;
        run_to(155); chk("sr_active155", div_active, 0);
        run_to(156); chk("sr_noticks", tick_cnt, 0);
        chk("sr_active156", div_active, 1);
        run_to(157); chk("sr_clk157", clk_div, 1);
        chk("sr_tick157", tick, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
